// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
// Purpose: FSM state encoding and bit-counter width helper used by serial_adder.
// Ports: none (package).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must index bits 0..width-1; a 1-bit minimum keeps WIDTH=2 legal.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - full adder built from two half adders and an OR
// Purpose: one-bit full adder used by the serial adder datapath.
// Ports:
//   a, b   in  1  operand bits
//   cin    in  1  carry in
//   sum    out 1  a ^ b ^ cin
//   cout   out 1  a&b | cin&(a^b)
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ab_sum;
    logic ab_carry;
    logic cin_carry;

    half_adder u_ha_ab (
        .a     (a),
        .b     (b),
        .sum   (ab_sum),
        .carry (ab_carry)
    );

    half_adder u_ha_cin (
        .a     (ab_sum),
        .b     (cin),
        .sum   (sum),
        .carry (cin_carry)
    );

    assign cout = ab_carry | cin_carry;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder cell
// Purpose: combinational half adder, building block of full_adder_cell.
// Ports:
//   a, b   in  1  operand bits
//   sum    out 1  a ^ b
//   carry  out 1  a & b
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, registered carry
// Purpose: loads two operands on Start, adds one bit per clock, presents a
//   registered Sum/CarryOut with a one-cycle Done pulse.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the Sub input (A-B).
// Ports:
//   Clk       in   1      rising-edge clock
//   Reset     in   1      asynchronous active-high reset
//   Start     in   1      load request, honoured only in IDLE
//   OperandA  in   WIDTH  augend
//   OperandB  in   WIDTH  addend
//   Sub       in   1      (SERIAL_ADDER_SUB_EN only) subtract when 1
//   Busy      out  1      high while in RUN
//   Done      out  1      one-cycle pulse when results become valid
//   Sum       out  WIDTH  registered result
//   CarryOut  out  1      carry out of MSB (no-borrow flag when subtracting)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut
);

    localparam int              CW   = count_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-2:0] psum;
    logic             carry;
    logic [CW-1:0]    count;
    logic             bit_sum;
    logic             bit_carry;
    logic             sub_sel;
    logic [WIDTH-1:0] sum_next;
    logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = Sub;
`else
    assign sub_sel = 1'b0;
`endif

    full_adder_cell u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry),
        .sum  (bit_sum),
        .cout (bit_carry)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at position 0.
    assign sum_next = {bit_sum, psum};
    assign last_bit = (count == LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            psum     <= '0;
            carry    <= 1'b0;
            count    <= '0;
            Sum      <= '0;
            CarryOut <= 1'b0;
        end else if (state == IDLE) begin
            if (Start) begin
                // Subtraction is A + ~B + 1: invert B, seed the carry with 1.
                a_reg <= OperandA;
                b_reg <= sub_sel ? ~OperandB : OperandB;
                carry <= sub_sel;
                psum  <= '0;
                count <= '0;
            end
        end else if (state == RUN) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            carry <= bit_carry;
            psum  <= sum_next[WIDTH-1:1];
            if (last_bit) begin
                Sum      <= sum_next;
                CarryOut <= bit_carry;
            end else begin
                // Held on the final bit so the counter never wraps inside RUN.
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         Sub;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         CarryOut;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .OperandA (OperandA),
        .OperandB (OperandB),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub      (Sub),
`endif
        .Busy     (Busy),
        .Done     (Done),
        .Sum      (Sum),
        .CarryOut (CarryOut)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at any time with the DUT idle; leaves at the negedge after the
    // DONE cycle (DUT back in IDLE).
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] exp_sum, input logic exp_co,
                          input logic [W-1:0] prev_sum, input logic prev_co);
        @(negedge Clk);
        Start    = 1'b1;
        OperandA = a;
        OperandB = b;
        Sub      = sub;
        for (int i = 0; i < W; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                Start    = 1'b0;
                OperandA = ~a;
                OperandB = ~b;
                Sub      = ~sub;
            end
            check({tag, " busy"}, Busy, 1);
            check({tag, " no_done"}, Done, 0);
            check({tag, " sum_held"}, Sum, prev_sum);
            check({tag, " co_held"}, CarryOut, prev_co);
        end
        @(negedge Clk);
        check({tag, " done"}, Done, 1);
        check({tag, " busy_off"}, Busy, 0);
        check({tag, " sum"}, Sum, exp_sum);
        check({tag, " co"}, CarryOut, exp_co);
        @(negedge Clk);
        check({tag, " done_pulse"}, Done, 0);
        check({tag, " sum_hold"}, Sum, exp_sum);
        check({tag, " co_hold"}, CarryOut, exp_co);
    endtask

    initial begin
        int done_cyc[$];
        int cyc;
        int pulses;
        logic prev_done;

        Reset    = 1'b1;
        Start    = 1'b0;
        OperandA = '0;
        OperandB = '0;
        Sub      = 1'b0;
        #1;
        check("rst busy", Busy, 0);
        check("rst done", Done, 0);
        check("rst sum", Sum, 0);
        check("rst co", CarryOut, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Basic add and carry-out cases; later ops confirm results are held.
        run_op("3C+0F", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b0);
        run_op("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h4B, 1'b0);
        repeat (3) @(negedge Clk);
        check("idle busy", Busy, 0);
        check("idle sum_held", Sum, 8'h00);
        check("idle co_held", CarryOut, 1);

        // Second Start during RUN must be ignored.
        @(negedge Clk);
        Start = 1'b1; OperandA = 8'h12; OperandB = 8'h34;
        pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge Clk);
            if (i == 1) Start = 1'b0;
            if (i == 3) begin Start = 1'b1; OperandA = 8'hFF; OperandB = 8'hFF; end
            if (i == 4) Start = 1'b0;
            if (i < W) check("ign sum_held", Sum, 8'h00);
            if (Done) begin
                pulses++;
                check("ign done_cycle", i, W + 1);
                check("ign sum", Sum, 8'h46);
                check("ign co", CarryOut, 0);
            end
        end
        check("ign pulses", pulses, 1);
        check("ign idle", Busy, 0);

        // Start held high: one result every W+2 cycles, single-cycle Done.
        @(negedge Clk);
        Start = 1'b1; OperandA = 8'h01; OperandB = 8'h01;
        cyc = 0;
        prev_done = 1'b0;
        while (done_cyc.size() < 3 && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (prev_done) check("held done_width", Done, 0);
            if (Done) begin
                done_cyc.push_back(cyc);
                check("held sum", Sum, 8'h02);
                check("held co", CarryOut, 0);
            end
            prev_done = Done;
        end
        Start = 1'b0;
        check("held pulses", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("held first", done_cyc[0], W + 1);
            check("held period1", done_cyc[1] - done_cyc[0], W + 2);
            check("held period2", done_cyc[2] - done_cyc[1], W + 2);
        end
        @(negedge Clk);
        check("held done_width_last", Done, 0);
        @(negedge Clk);
        check("held stop", Busy, 0);

        // Reset in the middle of RUN clears outputs without waiting for a clock.
        @(negedge Clk);
        Start = 1'b1; OperandA = 8'h3C; OperandB = 8'h0F;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("mid busy_pre", Busy, 1);
        #1;
        Reset = 1'b1;
        #1;
        check("arst busy", Busy, 0);
        check("arst done", Done, 0);
        check("arst sum", Sum, 0);
        check("arst co", CarryOut, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst hold busy", Busy, 0);
            check("rst hold sum", Sum, 0);
        end
        Reset = 1'b0;
        run_op("A5+5A", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 8'hFF, 1'b0);
        run_op("07-05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 8'hFE, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
